fifo_pop_ctrl: RTL and testbench

//  Read-side controller for a PCIe QoS class FIFO: issues POP while the source FIFO

---
 rtl/fifo_pop_ctrl.sv | 132 +++++++++++++
 tb/tb_fifo_pop_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pop_ctrl.sv
// fifo_pop_ctrl: read-side controller between a QoS class FIFO and the arbiter
// queue. It pops the source FIFO and forwards words downstream through a skid
// buffer that absorbs the source's 1-cycle read latency.
//
// Ports:
//   CLOCK, RESET      rising-edge clock, asynchronous active-high reset
//   ENABLE            1 = fetch from source, 0 = stop popping and drain
//   EMPTY, DATO_IN    source FIFO status and read data (valid cycle after POP)
//   POP               pop request to source FIFO
//   DEST_FULL         downstream FIFO full
//   PUSH_OUT, DATO_OUT  push strobe and data to downstream FIFO
//   IDLE              FSM idle, nothing in flight, skid empty
//   POP_COUNT         words forwarded, 8-bit wrapping (FIFO_POP_COUNT_EN only)
//
// Optional feature macro: FIFO_POP_COUNT_EN adds the POP_COUNT port/counter.
module fifo_pop_ctrl #(
    parameter int WIDTH      = 4,
    parameter int SKID_DEPTH = 2
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             EMPTY,
    input  logic [WIDTH-1:0] DATO_IN,
    output logic             POP,
    input  logic             DEST_FULL,
    output logic             PUSH_OUT,
    output logic [WIDTH-1:0] DATO_OUT,
`ifdef FIFO_POP_COUNT_EN
    output logic             IDLE,
    output logic [7:0]       POP_COUNT
`else
    output logic             IDLE
`endif
);

    localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int OW = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HOLD   = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] skid_q [SKID_DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [OW-1:0]    occ_q, occ_d;
    logic             inflight_q;
    logic             cap;
    logic             push;
    logic [OW:0]      fill;
`ifdef FIFO_POP_COUNT_EN
    logic [7:0]       cnt_q;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // The word popped last cycle lands on DATO_IN now and is captured this edge.
    assign cap  = inflight_q;
    assign push = (occ_q != '0) & ~DEST_FULL;

    // Skid slots committed once this cycle's push leaves; a new pop must fit.
    assign fill = (OW+1)'(occ_q) + (OW+1)'(inflight_q) - (OW+1)'(push);

    assign POP = ENABLE & ~EMPTY & (state_q == S_ACTIVE)
               & (fill < (OW+1)'(SKID_DEPTH));

    assign PUSH_OUT = push;
    assign DATO_OUT = (occ_q != '0) ? skid_q[rd_ptr_q] : '0;
    assign IDLE     = (state_q == S_IDLE) & (occ_q == '0) & ~inflight_q;
    assign occ_d    = occ_q + OW'(cap) - OW'(push);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (ENABLE && !EMPTY) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (!ENABLE)
                    state_d = S_DRAIN;
                else if (DEST_FULL && occ_q == OW'(SKID_DEPTH))
                    state_d = S_HOLD;
                else if (EMPTY && occ_q == '0 && !inflight_q)
                    state_d = S_IDLE;
            end
            S_HOLD: begin
                if (!DEST_FULL) state_d = ENABLE ? S_ACTIVE : S_DRAIN;
            end
            S_DRAIN: begin
                if (occ_q == '0 && !inflight_q) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
`ifdef FIFO_POP_COUNT_EN
            cnt_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= POP;
            if (cap)  wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (push) rd_ptr_q <= ptr_inc(rd_ptr_q);
`ifdef FIFO_POP_COUNT_EN
            if (push) cnt_q <= cnt_q + 8'd1;
`endif
        end
    end

    // Storage needs no reset: DATO_OUT is gated by occupancy.
    always_ff @(posedge CLOCK) begin
        if (cap) skid_q[wr_ptr_q] <= DATO_IN;
    end

`ifdef FIFO_POP_COUNT_EN
    assign POP_COUNT = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// tb_fifo_pop_ctrl: directed bench for fifo_pop_ctrl with a behavioural
// source FIFO and a push monitor.
module tb_fifo_pop_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       dest_full = 1'b0;
    logic       empty;
    logic [3:0] dato_in = 4'd0;
    logic       pop, push, idle;
    logic [3:0] dato_out;
`ifdef FIFO_POP_COUNT_EN
    logic [7:0] pcnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop   = 0;

    logic [3:0] mem [512];
    int         src_wr = 0;
    int         src_rd = 0;
    logic [3:0] got [$];

    fifo_pop_ctrl #(.WIDTH(4), .SKID_DEPTH(2)) dut (
        .CLOCK     (clk),
        .RESET     (rst),
        .ENABLE    (en),
        .EMPTY     (empty),
        .DATO_IN   (dato_in),
        .POP       (pop),
        .DEST_FULL (dest_full),
        .PUSH_OUT  (push),
        .DATO_OUT  (dato_out),
`ifdef FIFO_POP_COUNT_EN
        .IDLE      (idle),
        .POP_COUNT (pcnt)
`else
        .IDLE      (idle)
`endif
    );

    always #5 clk = ~clk;

    // Source FIFO: registered EMPTY, read data valid the cycle after POP.
    assign empty = (src_wr == src_rd);
    always @(posedge clk) begin
        if (pop) begin
            dato_in <= mem[src_rd % 512];
            src_rd  <= src_rd + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] v);
        mem[src_wr % 512] = v;
        src_wr++;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (push) begin
                got.push_back(dato_out);
                chk("no_push_when_full", {31'd0, dest_full}, 32'd0);
            end
            if (pop) begin
                n_pop++;
                chk("no_pop_when_empty", {31'd0, empty}, 32'd0);
            end
        end
    end

    logic [8:0] e2_pop  = 9'b000011110;
    logic [8:0] e2_push = 9'b001111000;
    logic [8:0] e2_idle = 9'b100000001;
    logic [5:0] e4_pop  = 6'b000010;
    logic [5:0] e4_push = 6'b001000;
    logic [5:0] e4_idle = 6'b100001;
    logic [6:0] e3_pop  = 7'b0001110;
    logic [6:0] e3_push = 7'b0001000;
    int         pop0;
    bit         done;

    initial begin
        // Reset with three words waiting and ENABLE high.
        en = 1'b1;
        load(4'd1); load(4'd2); load(4'd3);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("rst_pop", pop, 0);
        chk("rst_push", push, 0);
        chk("rst_idle", idle, 1);
        chk("rst_dato", dato_out, 0);
`ifdef FIFO_POP_COUNT_EN
        chk("rst_count", pcnt, 0);
`endif
        @(posedge clk); #1;
        src_wr = src_rd;
        rst = 1'b0;

        // Streaming 4,5,6,7 with downstream ready.
        @(posedge clk); #1;
        got.delete();
        load(4'd4); load(4'd5); load(4'd6); load(4'd7);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(posedge clk);
            @(negedge clk);
            chk($sformatf("t2_pop_c%0d", i), pop, e2_pop[i]);
            chk($sformatf("t2_push_c%0d", i), push, e2_push[i]);
            chk($sformatf("t2_idle_c%0d", i), idle, e2_idle[i]);
            if (e2_push[i])
                chk($sformatf("t2_dato_c%0d", i), dato_out, i + 1);
        end
        chk("t2_count", got.size(), 4);

        // Single word: one pop, then back to idle.
        @(posedge clk); #1;
        pop0 = n_pop;
        load(4'd3);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(posedge clk);
            @(negedge clk);
            chk($sformatf("t4_pop_c%0d", i), pop, e4_pop[i]);
            chk($sformatf("t4_push_c%0d", i), push, e4_push[i]);
            chk($sformatf("t4_idle_c%0d", i), idle, e4_idle[i]);
            if (e4_push[i]) chk("t4_dato", dato_out, 3);
        end
        chk("t4_one_pop", n_pop - pop0, 1);

        // ENABLE drops the cycle after the first pop.
        @(posedge clk); #1;
        load(4'd1); load(4'd2); load(4'd3);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
                if (i == 2) en = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("t5_pop_c%0d", i), pop, e4_pop[i]);
            chk($sformatf("t5_push_c%0d", i), push, e4_push[i]);
            chk($sformatf("t5_idle_c%0d", i), idle, e4_idle[i]);
            if (e4_push[i]) chk("t5_dato", dato_out, 1);
            if (i == 3 || i == 4)
                chk($sformatf("t5_drain_c%0d", i), dut.state_q, 3);
        end
        @(posedge clk); #1;
        src_wr = src_rd;

        // Downstream stalls after the first push; eight words 8..15.
        @(posedge clk); #1;
        got.delete();
        en = 1'b1;
        for (int k = 8; k < 16; k++) load(4'(k));
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
                if (i == 4) dest_full = 1'b1;
            end
            @(negedge clk);
            if (i < 7) begin
                chk($sformatf("t3_pop_c%0d", i), pop, e3_pop[i]);
                chk($sformatf("t3_push_c%0d", i), push, e3_push[i]);
            end else begin
                chk($sformatf("t3_holdpop_c%0d", i), pop, 0);
            end
            if (i == 3) chk("t3_first", dato_out, 8);
            if (i == 5) chk("t3_head", dato_out, 9);
            if (i == 6) chk("t3_hold", dut.state_q, 2);
        end
        @(posedge clk); #1;
        dest_full = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (idle) done = 1'b1;
            else @(posedge clk);
        end
        chk("t3_idle_reached", idle, 1);
        chk("t3_words", got.size(), 8);
        for (int k = 0; k < 8 && k < got.size(); k++)
            chk($sformatf("t3_order_%0d", k), got[k], 8 + k);

        // Reset mid-operation with a full skid buffer.
        @(posedge clk); #1;
        dest_full = 1'b1;
        for (int k = 1; k < 7; k++) load(4'(k));
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        chk("mr_holdpop", pop, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mr_push", push, 0);
        chk("mr_idle", idle, 1);
        chk("mr_dato", dato_out, 0);
        @(posedge clk); #1;
        src_wr = src_rd;
        en = 1'b0;
        dest_full = 1'b0;
        rst = 1'b0;
        got.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("mr_nopush_%0d", i), push, 0);
        end
        chk("mr_discarded", got.size(), 0);

`ifdef FIFO_POP_COUNT_EN
        // Forward 260 words: counter wraps to 4.
        @(posedge clk); #1;
        en = 1'b1;
        for (int k = 0; k < 260; k++) load(4'(k));
        for (int i = 0; i < 3; i++) @(posedge clk);
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (idle) done = 1'b1;
            else @(posedge clk);
        end
        chk("cnt_idle_reached", idle, 1);
        chk("cnt_words", got.size(), 260);
        chk("cnt_wrap", pcnt, 4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
